// File: rtl/microbot_pkg.sv
// Shared encodings for the microbot motion path: command codes, H-bridge
// patterns, sequencer state encoding and the command-to-pattern lookup.
package microbot_pkg;

  localparam logic [1:0] CMD_STANDBY = 2'b00;
  localparam logic [1:0] CMD_FWD     = 2'b01;
  localparam logic [1:0] CMD_RIGHT   = 2'b10;
  localparam logic [1:0] CMD_LEFT    = 2'b11;

  // {A_d, A_i, B_d, B_i}; no pattern drives both pins of one bridge
  localparam logic [3:0] PAT_STANDBY = 4'b0000;
  localparam logic [3:0] PAT_FWD     = 4'b1010;
  localparam logic [3:0] PAT_RIGHT   = 4'b1001;
  localparam logic [3:0] PAT_LEFT    = 4'b0110;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

  function automatic logic [3:0] motor_pattern(input logic [1:0] c);
    logic [3:0] p;
    case (c)
      CMD_FWD:   p = PAT_FWD;
      CMD_RIGHT: p = PAT_RIGHT;
      CMD_LEFT:  p = PAT_LEFT;
      default:   p = PAT_STANDBY;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cmd_debounce.sv
// Command debouncer: filt_cmd follows cmd only after it has been sampled
// unchanged long enough for the run counter to reach DEBOUNCE_CYCLES-1.
module cmd_debounce
  import microbot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cmd,
  output logic [1:0] filt_cmd
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       cmd_q, cmd_d;
  logic [1:0]       filt_q, filt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;

  always_comb begin
    cmd_d  = cmd_q;
    filt_d = filt_q;
    dcnt_d = dcnt_q;
    if (cmd != cmd_q) begin
      cmd_d  = cmd;
      dcnt_d = '0;
    end else if (dcnt_q == DB_LAST) begin
      // counter parks here; filt keeps re-latching the same stable value
      filt_d = cmd_q;
    end else begin
      dcnt_d = dcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q  <= CMD_STANDBY;
      filt_q <= CMD_STANDBY;
      dcnt_q <= '0;
    end else begin
      cmd_q  <= cmd_d;
      filt_q <= filt_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign filt_cmd = filt_q;

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Motion command sequencer: debounced command in, registered H-bridge pins
// out, with a minimum dwell per motion and all-off dead time between motions.
module motor_cmd_sequencer
  import microbot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEAD_CYCLES     = 8,
  parameter int DWELL_CYCLES    = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] cmd,
  output logic [3:0] motors,
  output logic [1:0] active_cmd,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);

  logic [1:0] filt_cmd;

  cmd_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .cmd     (cmd),
    .filt_cmd(filt_cmd)
  );

  state_e           state_q, state_d;
  logic [3:0]       motors_q, motors_d;
  logic [1:0]       active_q, active_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  logic start_ok;
  assign start_ok = enable && (filt_cmd != CMD_STANDBY);

  always_comb begin
    state_d  = state_q;
    motors_d = motors_q;
    active_d = active_q;
    tcnt_d   = tcnt_q;
    case (state_q)
      ST_STOP: begin
        motors_d = PAT_STANDBY;
        active_d = CMD_STANDBY;
        if (start_ok) begin
          state_d  = ST_RUN;
          active_d = filt_cmd;
          motors_d = motor_pattern(filt_cmd);
          tcnt_d   = DWELL_LAST;
        end
      end
      ST_RUN: begin
        if (tcnt_q != '0) tcnt_d = tcnt_q - CNT_W'(1);
        // disable overrides dwell; a command change waits for dwell to expire
        if (!enable || (tcnt_q == '0 && filt_cmd != active_q)) begin
          state_d  = ST_DEAD;
          motors_d = PAT_STANDBY;
          active_d = CMD_STANDBY;
          tcnt_d   = DEAD_LAST;
        end
      end
      ST_DEAD: begin
        if (tcnt_q == '0) begin
          if (start_ok) begin
            state_d  = ST_RUN;
            active_d = filt_cmd;
            motors_d = motor_pattern(filt_cmd);
            tcnt_d   = DWELL_LAST;
          end else begin
            state_d = ST_STOP;
          end
        end else begin
          tcnt_d = tcnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_STOP;
        motors_d = PAT_STANDBY;
        active_d = CMD_STANDBY;
        tcnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_STOP;
      motors_q <= PAT_STANDBY;
      active_q <= CMD_STANDBY;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      motors_q <= motors_d;
      active_q <= active_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign motors     = motors_q;
  assign active_cmd = active_q;
  assign busy       = (state_q != ST_STOP);

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed vector table, corner-case sequences
// and random stimulus against a timestamp-based behavioural model.
module tb_motor_cmd_sequencer;

  localparam int DB    = 4;
  localparam int DEAD  = 8;
  localparam int DWELL = 16;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_GAP  = 2;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [1:0] cmd;
  logic [3:0] motors;
  logic [1:0] active_cmd;
  logic       busy;

  motor_cmd_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .DEAD_CYCLES    (DEAD),
    .DWELL_CYCLES   (DWELL),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cmd       (cmd),
    .motors    (motors),
    .active_cmd(active_cmd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: run-length debouncer plus edge timestamps for dwell / gap timing
  logic [3:0] pats [4] = '{4'b0000, 4'b1010, 4'b1001, 4'b0110};
  logic [1:0] m_last, m_filt, m_act;
  int         m_run, m_mode, m_t0, cyc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, got, want, cyc);
    end
  endtask

  function automatic void model_edge(input logic r, input logic e, input logic [1:0] c);
    cyc++;
    if (r) begin
      m_last = 2'b00; m_run = 1; m_filt = 2'b00;
      m_mode = M_IDLE; m_act = 2'b00;
      return;
    end
    case (m_mode)
      M_IDLE: if (e && m_filt != 2'b00) begin
        m_mode = M_MOVE; m_act = m_filt; m_t0 = cyc;
      end
      M_MOVE: if (!e || (cyc - m_t0 >= DWELL && m_filt != m_act)) begin
        m_mode = M_GAP; m_act = 2'b00; m_t0 = cyc;
      end
      default: if (cyc - m_t0 >= DEAD) begin
        if (e && m_filt != 2'b00) begin
          m_mode = M_MOVE; m_act = m_filt; m_t0 = cyc;
        end else begin
          m_mode = M_IDLE;
        end
      end
    endcase
    // filter passes a value once it has been seen on DB+1 consecutive edges
    if (c == m_last) begin
      if (m_run < DB + 1) m_run++;
    end else begin
      m_last = c; m_run = 1;
    end
    if (m_run >= DB + 1) m_filt = m_last;
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] c);
    reset = r; enable = e; cmd = c;
    @(posedge clk);
    model_edge(r, e, c);
    #1;
    chk("motors", motors, pats[m_act]);
    chk("active_cmd", active_cmd, m_act);
    chk("busy", busy, m_mode != M_IDLE);
    chk("bridge_pairs", {motors[3] & motors[2], motors[1] & motors[0]}, 0);
  endtask

  task automatic run_until(input logic [3:0] pat, input logic e, input logic [1:0] c,
                           input string name);
    for (int i = 0; i < 60 && motors !== pat; i++) step(1'b0, e, c);
    chk(name, motors, pat);
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] c;
    logic [3:0] mot;
    logic [1:0] act;
    logic       bsy;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int n, zeros;
    logic changed, left;
    reset = 1'b1; enable = 1'b0; cmd = 2'b00;
    cyc = 0; m_t0 = 0;
    m_last = 2'b00; m_run = 1; m_filt = 2'b00; m_act = 2'b00; m_mode = M_IDLE;

    // reset, then forward held: five quiet edges, pattern on the sixth
    tbl[0] = '{1'b1, 1'b0, 2'b00, 4'b0000, 2'b00, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 2'b01, 4'b0000, 2'b00, 1'b0};
    for (int i = 2; i < 7; i++) tbl[i] = '{1'b0, 1'b1, 2'b01, 4'b0000, 2'b00, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 2'b01, 4'b1010, 2'b01, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 2'b01, 4'b1010, 2'b01, 1'b1};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].c);
      chk("tbl_motors", motors, tbl[i].mot);
      chk("tbl_active", active_cmd, tbl[i].act);
      chk("tbl_busy", busy, tbl[i].bsy);
    end

    // dwell expired, switch to right: exactly DEAD all-off cycles
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'b01);
    zeros = 0; left = 1'b0;
    for (int i = 0; i < 60 && motors !== 4'b1001; i++) begin
      step(1'b0, 1'b1, 2'b10);
      if (motors === 4'b0000) begin zeros++; left = 1'b1; end
    end
    chk("right_reached", motors, 4'b1001);
    chk("dead_len", zeros, DEAD);

    // 3-cycle glitch must not disturb the running motion
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'b10);
    changed = 1'b0;
    for (int i = 0; i < 3; i++) begin step(1'b0, 1'b1, 2'b01); changed |= (motors !== 4'b1001); end
    for (int i = 0; i < 12; i++) begin step(1'b0, 1'b1, 2'b10); changed |= (motors !== 4'b1001); end
    chk("glitch_hold", changed, 1'b0);

    // early change: old pattern holds for the full dwell from RUN entry
    step(1'b1, 1'b0, 2'b00);
    run_until(4'b1010, 1'b1, 2'b01, "fwd_start");
    n = 1;
    step(1'b0, 1'b1, 2'b01); n += (motors === 4'b1010);
    step(1'b0, 1'b1, 2'b01); n += (motors === 4'b1010);
    for (int i = 0; i < 40 && motors === 4'b1010; i++) begin
      step(1'b0, 1'b1, 2'b11);
      if (motors === 4'b1010) n++;
    end
    chk("dwell_len", n, DWELL);
    run_until(4'b0110, 1'b1, 2'b11, "left_reached");

    // enable drop mid-RUN: immediate off, STOP after the dead time
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b0, 2'b00);
    chk("drop_off", motors, 4'b0000);
    for (int i = 0; i < DEAD; i++) step(1'b0, 1'b0, 2'b00);
    chk("drop_stop_busy", busy, 1'b0);
    n = 0;
    for (int i = 0; i < 30 && motors !== 4'b0110; i++) begin step(1'b0, 1'b1, 2'b11); n++; end
    chk("reenable_latency", n, DB + 2);

    // reset during RUN, then during DEAD
    step(1'b1, 1'b1, 2'b11);
    chk("rst_run", {motors, active_cmd, busy}, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'b00);
    chk("rst_stays_stop", busy, 1'b0);
    run_until(4'b1010, 1'b1, 2'b01, "fwd_again");
    step(1'b0, 1'b0, 2'b01);
    step(1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b01);
    chk("rst_dead", {motors, active_cmd, busy}, 0);

    // random: held commands of random length, sparse disable and reset
    for (int blk = 0; blk < 400; blk++) begin
      logic [1:0] c;
      logic       e;
      int         len;
      c   = 2'($urandom_range(0, 3));
      e   = ($urandom_range(0, 7) != 0);
      len = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30));
      for (int k = 0; k < len; k++) step($urandom_range(0, 199) == 0, e, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
- Sits between the navigation FSM's 2-bit motion command and the four H-bridge motor pins. Every motor pin change passes through this block.
- Debounces the command and enforces a minimum dwell time per motion. Inserts an all-off dead time on every direction change so neither bridge ever switches polarity within one cycle.
- Motor outputs are registered, so they never glitch.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical cmd samples required before the filtered command updates (>=1).
- DEAD_CYCLES, 8, cycles motors are held at 4'b0000 between two motions (>=1).
- DWELL_CYCLES, 16, minimum cycles a motion is held before a change is accepted (>=1).
- CNT_W, 8, shared counter width; must hold max(parameter)-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, motion is stopped via dead time.
- cmd  input  2  requested motion: 00 Standby, 01 forward, 10 right, 11 left.
- motors  output   4  {A_d, A_i, B_d, B_i} = bits [3:0], registered.
- active_cmd  output  2  motion currently driven (00 when not in RUN).
- busy  output  1  high when state != STOP.

Behaviour:
- Reset (synchronous): state=STOP, motors=0000, active_cmd=00, busy=0, filt_cmd=00, cmd_q=00, all counters 0. Reset mid-RUN drops motors to 0000 at that edge, with no dead-time sequencing.
- Motor patterns:
  - Standby: 0000.
  - forward: 1010.
  - right: 1001.
  - left: 0110.
  - Pattern is never 11 on either bridge pair.
- Debouncer, per edge:
  - If cmd != cmd_q: cmd_q<=cmd, dcnt<=0.
  - Else if dcnt==DEBOUNCE_CYCLES-1: filt_cmd<=cmd_q, and dcnt holds.
  - Else dcnt++.
  - A pulse shorter than DEBOUNCE_CYCLES never reaches filt_cmd.
- FSM states: STOP, RUN, DEAD.
- STOP:
  - motors=0000.
  - If enable && filt_cmd!=00, go to RUN at the next edge: active_cmd<=filt_cmd, motors<=pattern(filt_cmd), tcnt<=DWELL_CYCLES-1.
- RUN:
  - motors=pattern(active_cmd); tcnt decrements to 0 and saturates.
  - If !enable, go to DEAD at the next edge, regardless of tcnt.
  - Else if tcnt==0 && filt_cmd!=active_cmd, go to DEAD.
  - If filt_cmd returns to active_cmd before dwell expires, no transition occurs.
- DEAD:
  - Entry edge: motors<=0000, active_cmd<=00, tcnt<=DEAD_CYCLES-1.
  - Decrement each cycle. On the edge where tcnt==0, sample filt_cmd and enable:
    - If enable && filt_cmd!=00, go to RUN with the new command.
    - Otherwise go to STOP.
  - motors is 0000 for exactly DEAD_CYCLES cycles.
  - Changes to filt_cmd during DEAD are ignored until the exit edge. Re-requesting the same motion still costs the full dead time.
- Latency from STOP:
  - Let E be the first edge sampling a new stable cmd.
  - filt_cmd updates at E+DEBOUNCE_CYCLES.
  - motors update at E+DEBOUNCE_CYCLES+1 (edge 6 counting E as 1, defaults).
- Counter arithmetic is unsigned CNT_W with no wrap: tcnt saturates at 0 in RUN.

Decomposition:
- Package microbot_pkg:
  - cmd codes (CMD_STANDBY, CMD_FWD, CMD_RIGHT, CMD_LEFT).
  - motor pattern constants.
  - FSM state encoding (STOP=2'b00, RUN=2'b01, DEAD=2'b10).
  - pattern-lookup function.
- One sub-module, cmd_debounce (cmd, clk, reset -> filt_cmd), parameterised by DEBOUNCE_CYCLES and CNT_W.
- Dead time, dwell and the FSM stay in motor_cmd_sequencer.

Test Plan:
- Reset, then enable=1, cmd=01 held -> motors 0000 for 5 edges, 1010 at the 6th edge, busy=1, active_cmd=01.
- In forward with dwell expired, cmd=10 -> after debounce, motors=0000 for exactly 8 cycles, then 1001. No cycle ever has A_d&A_i or B_d&B_i set.
- Glitch: cmd 01->11 for 3 cycles, then back to 01 -> filt_cmd never 11, motors stay 1010, no dead-time entry.
- Change requested 2 cycles after entering RUN -> motors hold the old pattern until 16 cycles after RUN entry, then enter 8-cycle dead time.
- enable drops mid-RUN (dwell not expired) -> motors 0000 at the next edge, STOP after 8 cycles, busy=0. Re-asserting enable with cmd=11 stable -> 0110 after 5 further edges.
- reset asserted during DEAD and during RUN -> motors 0000, active_cmd 00, busy 0 at that edge. Release with cmd=00 -> remains in STOP.
